// File: rtl/serial_mod_checker_pkg.sv
// serial_mod_checker_pkg: shared FSM state type and width helper
package serial_mod_checker_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mod_add_reduce.sv
// mod_add_reduce: (a + b) mod MOD for operands already below MOD
module mod_add_reduce
  import serial_mod_checker_pkg::*;
#(
  parameter int MOD = 3,
  parameter int RW  = clog2(MOD)
) (
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] y
);
  localparam logic [RW:0] MODV = (RW+1)'(MOD);
  logic [RW:0] s;
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    y = s >= MODV ? RW'(s - MODV) : s[RW-1:0];
  end
endmodule

// File: rtl/serial_mod_checker.sv
// serial_mod_checker: running remainder of a serial frame modulo MOD
module serial_mod_checker
  import serial_mod_checker_pkg::*;
#(
  parameter int MOD    = 3,
  parameter int MAXLEN = 32,
  localparam int RW    = clog2(MOD),
  localparam int CW    = clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          lsb_first,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          last,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rem_out,
  output logic          divisible,
  output logic          overflow
);
  localparam logic [RW:0] MODV = (RW+1)'(MOD);
  state_t state, state_nx;
  logic [RW-1:0] r, w, r_base, w_base, r_msb, r_lsb, w_dbl, r_nx, lsb_term;
  logic [RW:0] msb_sum;
  logic [CW-1:0] cnt, cnt_base;
  logic lsb, lsb_base, in_frame, accept, drop, close;
  // start acts on this cycle's bit, so all updates work from the frame-start values
  always_comb begin
    r_base   = start ? '0 : r;
    w_base   = start ? RW'(1) : w;
    cnt_base = start ? '0 : cnt;
    lsb_base = start ? lsb_first : lsb;
    in_frame = start || state == ACCUM;
    accept   = in_frame && bit_valid && cnt_base < CW'(MAXLEN);
    drop     = in_frame && bit_valid && !accept;
    close    = in_frame && bit_valid && last;
    msb_sum  = {r_base, bit_in};
    r_msb    = msb_sum >= MODV ? RW'(msb_sum - MODV) : msb_sum[RW-1:0];
    lsb_term = bit_in ? w_base : '0;
    r_nx     = accept ? (lsb_base ? r_lsb : r_msb) : r_base;
    state_nx = close ? DONE : start ? ACCUM : state == DONE ? IDLE : state;
  end
  mod_add_reduce #(.MOD(MOD), .RW(RW)) u_rem (.a(r_base), .b(lsb_term), .y(r_lsb));
  mod_add_reduce #(.MOD(MOD), .RW(RW)) u_wgt (.a(w_base), .b(w_base), .y(w_dbl));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      r         <= '0;
      w         <= RW'(1);
      cnt       <= '0;
      lsb       <= 1'b0;
      rem_out   <= '0;
      divisible <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_nx;
      r        <= r_nx;
      w        <= accept && lsb_base ? w_dbl : w_base;
      cnt      <= accept ? cnt_base + CW'(1) : cnt_base;
      lsb      <= lsb_base;
      overflow <= (start ? 1'b0 : overflow) | drop;
      if (close) begin
        rem_out   <= r_nx;
        divisible <= r_nx == '0;
      end
    end
  end
  assign busy = state == ACCUM;
  assign done = state == DONE;
endmodule

// File: tb/tb_serial_mod_checker.sv
// tb_serial_mod_checker: four parameterisations driven in parallel, scoreboard-checked
module tb_serial_mod_checker;
  typedef struct {int rem; int ovf;} exp_t;
  localparam int MODS [4] = '{3, 5, 7, 3};
  localparam int MLS  [4] = '{32, 32, 32, 4};
  logic clk = 0, reset = 1, start = 0, lsb_first = 0, bit_in = 0, bit_valid = 0, last = 0;
  logic [3:0] busy_v, done_v, div_v, ovf_v;
  logic [1:0] rem0, rem3;
  logic [2:0] rem1, rem2;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, n_done = 0, n_frames = 0;
  int grem [4];
  always #5 clk = ~clk;
  serial_mod_checker #(.MOD(3), .MAXLEN(32)) dut0 (.clk(clk), .reset(reset), .start(start),
    .lsb_first(lsb_first), .bit_in(bit_in), .bit_valid(bit_valid), .last(last), .busy(busy_v[0]),
    .done(done_v[0]), .rem_out(rem0), .divisible(div_v[0]), .overflow(ovf_v[0]));
  serial_mod_checker #(.MOD(5), .MAXLEN(32)) dut1 (.clk(clk), .reset(reset), .start(start),
    .lsb_first(lsb_first), .bit_in(bit_in), .bit_valid(bit_valid), .last(last), .busy(busy_v[1]),
    .done(done_v[1]), .rem_out(rem1), .divisible(div_v[1]), .overflow(ovf_v[1]));
  serial_mod_checker #(.MOD(7), .MAXLEN(32)) dut2 (.clk(clk), .reset(reset), .start(start),
    .lsb_first(lsb_first), .bit_in(bit_in), .bit_valid(bit_valid), .last(last), .busy(busy_v[2]),
    .done(done_v[2]), .rem_out(rem2), .divisible(div_v[2]), .overflow(ovf_v[2]));
  serial_mod_checker #(.MOD(3), .MAXLEN(4)) dut3 (.clk(clk), .reset(reset), .start(start),
    .lsb_first(lsb_first), .bit_in(bit_in), .bit_valid(bit_valid), .last(last), .busy(busy_v[3]),
    .done(done_v[3]), .rem_out(rem3), .divisible(div_v[3]), .overflow(ovf_v[3]));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && done_v != 4'h0) begin
      exp_t e;
      n_done++;
      grem = '{int'(rem0), int'(rem1), int'(rem2), int'(rem3)};
      chk("done_all", done_v, 4'hF);
      for (int d = 0; d < 4; d++) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("rem_out[%0d]", d), grem[d], e.rem);
          chk($sformatf("divisible[%0d]", d), div_v[d], e.rem == 0);
          chk($sformatf("overflow[%0d]", d), ovf_v[d], e.ovf);
        end
      end
    end
  end

  task automatic frame(input logic [31:0] seq, input int n, input bit lsb, input int gap_at,
                       input int gap_len, input bit sw);
    for (int d = 0; d < 4; d++) begin
      int k;
      longint v;
      k = n > MLS[d] ? MLS[d] : n;
      v = 0;
      for (int i = 0; i < k; i++) v = lsb ? v | (longint'(seq[i]) << i) : v * 2 + longint'(seq[i]);
      q.push_back('{rem: int'(v % MODS[d]), ovf: int'(n > MLS[d])});
    end
    n_frames++;
    if (!sw) begin
      start = 1; lsb_first = lsb; tick(); start = 0;
      chk("busy_after_start", busy_v, 4'hF);
    end
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bit_valid = 0; last = 0; start = 0;
        repeat (gap_len) tick();
      end
      start = sw && i == 0; lsb_first = lsb; bit_in = seq[i]; bit_valid = 1; last = i == n - 1;
      tick();
    end
    start = 0; bit_valid = 0; last = 0; bit_in = 0;
    chk("done_latency", done_v[0], 1);
    tick();
    chk("done_one_pulse", done_v[0], 0);
    tick();
  endtask

  task automatic partial(input logic [31:0] seq, input int n, input bit lsb);
    start = 1; lsb_first = lsb; tick(); start = 0;
    for (int i = 0; i < n; i++) begin
      bit_in = seq[i]; bit_valid = 1; last = 0; tick();
    end
    bit_valid = 0; bit_in = 0;
  endtask

  initial begin
    #1 reset = 0;
    #1;
    chk("rst_busy", busy_v, 0);
    chk("rst_done", done_v, 0);
    chk("rst_rem0", rem0, 0);
    chk("rst_rem1", rem1, 0);
    chk("rst_div", div_v, 0);
    chk("rst_ovf", ovf_v, 0);
    repeat (2) tick();
    reset = 1;
    tick();
    frame(32'b011, 3, 0, -1, 0, 0);
    frame(32'b1101, 4, 1, -1, 0, 0);
    repeat (3) tick();
    chk("hold_rem1", rem1, 3);
    chk("hold_div1", div_v[1], 0);
    chk("idle_busy", busy_v, 0);
    frame(32'b101, 3, 0, 1, 3, 0);
    frame(32'b11111, 5, 0, -1, 0, 0);
    tick();
    chk("hold_ovf3", ovf_v[3], 1);
    chk("hold_rem3", rem3, 0);
    partial(32'b11, 2, 0);
    frame(32'b01, 2, 0, -1, 0, 0);
    frame(32'b1, 1, 0, -1, 0, 1);
    frame(32'b1011, 4, 1, -1, 0, 1);
    for (int t = 0; t < 8; t++)
      frame(32'($urandom), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), -1, 0,
            1'($urandom_range(0, 1)));
    partial(32'hA5, 3, 1);
    #2 reset = 0;
    #1;
    chk("midrst_busy", busy_v, 0);
    chk("midrst_done", done_v, 0);
    chk("midrst_rem", {rem0, rem1, rem2, rem3}, 0);
    chk("midrst_div_ovf", {div_v, ovf_v}, 0);
    tick();
    reset = 1;
    tick();
    chk("post_rst_done", done_v, 0);
    frame(32'b1101, 4, 0, -1, 0, 0);
    repeat (2) tick();
    chk("done_count", n_done, n_frames);
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
